// File: rtl/lsu_pkg.sv
// Shared types for the MEM-stage load/store controller.
// Request bundle, FSM states and buffer depth.
package lsu_pkg;

  localparam int LSU_FIFO_DEPTH = 2;

  typedef enum logic [2:0] {
    IDLE,
    RREAD,
    RESP,
    WSETUP,
    WSTROBE,
    WHOLD
  } lsu_state_t;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [2:0]  rd;
  } lsu_req_t;

endpackage

// File: rtl/lsu_req_fifo.sv
// Two-entry request buffer: registered count, head/tail pointers.
// Full/empty flags are registered so req_ready comes straight from a flop.
module lsu_req_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = LSU_FIFO_DEPTH
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_push,
  input  lsu_req_t i_din,
  input  logic     i_pop,
  output lsu_req_t o_dout,
  output logic     o_full,
  output logic     o_empty
);

  lsu_req_t   r_mem [0:1];
  logic       r_head;
  logic       r_tail;
  logic [1:0] r_count;
  logic       r_full;
  logic       r_empty;
  logic [1:0] w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    if (i_push && !i_pop) begin
      w_count_nxt = r_count + 2'd1;
    end else if (!i_push && i_pop) begin
      w_count_nxt = r_count - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (i_push) r_tail <= ~r_tail;
      if (i_pop)  r_head <= ~r_head;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == 2'(DEPTH));
      r_empty <= (w_count_nxt == 2'd0);
    end
  end

  // Storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_tail] <= i_din;
  end

  assign o_dout  = r_mem[r_head];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store controller driving data_memory.
// Buffers two requests; stores run setup/strobe/hold, loads respond.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int FIFO_DEPTH = LSU_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [2:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic [2:0]  resp_rd,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [15:0] mem_rdata
);

  lsu_state_t  r_state;
  logic        r_resp_valid;
  logic [15:0] r_resp_data;
  logic [2:0]  r_resp_rd;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic        r_mem_read;
  logic        r_mem_write;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  lsu_req_t    w_din;
  lsu_req_t    w_head;

  assign w_din = '{
    we:    req_we,
    addr:  req_addr,
    wdata: req_wdata,
    rd:    req_rd
  };

  assign w_push = req_valid && !w_full;
  assign w_pop  = (r_state == IDLE) && !w_empty;

  lsu_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_rd    <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_mem_addr  <= w_head.addr;
            r_mem_wdata <= w_head.wdata;
            if (w_head.we) begin
              r_state <= WSETUP;
            end else begin
              r_resp_rd  <= w_head.rd;
              r_mem_read <= 1'b1;
              r_state    <= RREAD;
            end
          end
        end
        RREAD: begin
          r_resp_data  <= mem_rdata;
          r_resp_valid <= 1'b1;
          r_mem_read   <= 1'b0;
          r_state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        // Memory commits on the rising edge of write.
        WSETUP: begin
          r_mem_write <= 1'b1;
          r_state     <= WSTROBE;
        end
        WSTROBE: begin
          r_mem_write <= 1'b0;
          r_state     <= WHOLD;
        end
        WHOLD: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = !w_full;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_rd    = r_resp_rd;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;

endmodule
